// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: program load into imem, sequential
// prefetch into a small FIFO, HALT detection and delivery to IF.
module inst_fetch_unit #(
  parameter int INST_W     = 20,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_mode,
  input  logic              load_valid,
  input  logic [INST_W-1:0] load_inst,
  input  logic              start,
  input  logic              freeze,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [INST_W-1:0] mem_wr_data,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [INST_W-1:0] mem_rd_data,
  output logic [INST_W-1:0] inst_out,
  output logic              inst_valid,
  output logic [ADDR_W:0]   pc,
  output logic [ADDR_W:0]   prog_len,
  output logic              load_overflow,
  output logic              halted
);

  localparam int FPW = $clog2(FIFO_DEPTH);
  localparam int CW  = FPW + 1;

  localparam logic [INST_W-1:0] HALT_INST =
    {2'b11, {(INST_W-2){1'b0}}};
  localparam logic [ADDR_W:0] PC_ONE  = 1;
  localparam logic [FPW-1:0]  FP_ONE  = 1;
  localparam logic [CW-1:0]   CNT_ONE = 1;
  localparam logic [CW:0]     CREDIT  = FIFO_DEPTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_HALTED
  } state_t;

  state_t            r_state;
  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_prog_len;
  logic [ADDR_W:0]   r_pc;
  logic              r_overflow;
  logic              r_halted;
  logic              r_halt_fetched;
  logic              r_inflight;
  logic [INST_W-1:0] r_fifo [FIFO_DEPTH];
  logic [FPW-1:0]    r_rd_fp;
  logic [FPW-1:0]    r_wr_fp;
  logic [CW-1:0]     r_count;

  logic              w_run;
  logic              w_wr;
  logic [1:0]        w_ret_op;
  logic              w_ret_halt;
  logic [CW:0]       w_used;
  logic              w_credit;
  logic              w_rd;
  logic              w_synth;
  logic              w_push_ret;
  logic              w_push;
  logic [INST_W-1:0] w_push_data;
  logic              w_valid;
  logic [INST_W-1:0] w_head;
  logic              w_pop;
  logic              w_pop_halt;

  assign w_run = (r_state == S_RUN);

  assign w_wr = (r_state == S_LOAD) && load_mode
             && load_valid && !r_wr_ptr[ADDR_W];

  assign w_ret_op   = mem_rd_data[INST_W-1 -: 2];
  assign w_ret_halt = r_inflight && (w_ret_op == 2'b11);

  // A read in flight already owns a FIFO slot.
  assign w_used   = {1'b0, r_count}
                  + {{CW{1'b0}}, r_inflight};
  assign w_credit = (w_used < CREDIT);

  // Stop issuing in the very cycle a HALT comes back.
  assign w_rd = w_run && (r_pc < r_prog_len)
             && !r_halt_fetched && !w_ret_halt
             && w_credit;

  assign w_synth = w_run && (r_pc == r_prog_len)
                && !r_halt_fetched && !r_inflight
                && w_credit;

  assign w_push_ret  = w_run && r_inflight
                    && !r_halt_fetched;
  assign w_push      = w_push_ret || w_synth;
  assign w_push_data = w_synth ? HALT_INST : mem_rd_data;

  assign w_valid    = (r_count != '0);
  assign w_head     = r_fifo[r_rd_fp];
  assign w_pop      = w_run && w_valid && !freeze;
  assign w_pop_halt = w_pop
                   && (w_head[INST_W-1 -: 2] == 2'b11);

  assign mem_wr_en     = w_wr;
  assign mem_wr_addr   = w_wr ? r_wr_ptr[ADDR_W-1:0] : '0;
  assign mem_wr_data   = w_wr ? load_inst : '0;
  assign mem_rd_en     = w_rd;
  assign mem_rd_addr   = w_rd ? r_pc[ADDR_W-1:0] : '0;
  assign inst_valid    = w_valid;
  assign inst_out      = w_valid ? w_head : '0;
  assign pc            = r_pc;
  assign prog_len      = r_prog_len;
  assign load_overflow = r_overflow;
  assign halted        = r_halted;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_wr_ptr       <= '0;
      r_prog_len     <= '0;
      r_pc           <= '0;
      r_overflow     <= 1'b0;
      r_halted       <= 1'b0;
      r_halt_fetched <= 1'b0;
      r_inflight     <= 1'b0;
      r_rd_fp        <= '0;
      r_wr_fp        <= '0;
      r_count        <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        r_fifo[i] <= '0;
    end else begin
      r_inflight <= w_rd;
      if (w_rd)
        r_pc <= r_pc + PC_ONE;
      if (w_synth || (w_push_ret && w_ret_halt))
        r_halt_fetched <= 1'b1;

      if (w_push) begin
        r_fifo[r_wr_fp] <= w_push_data;
        r_wr_fp         <= r_wr_fp + FP_ONE;
      end
      if (w_pop)
        r_rd_fp <= r_rd_fp + FP_ONE;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase

      unique case (r_state)
        S_IDLE, S_HALTED: begin
          if (load_mode) begin
            r_state    <= S_LOAD;
            r_wr_ptr   <= '0;
            r_overflow <= 1'b0;
            r_halted   <= 1'b0;
          end else if (start) begin
            r_state        <= S_RUN;
            r_pc           <= '0;
            r_halted       <= 1'b0;
            r_halt_fetched <= 1'b0;
            r_inflight     <= 1'b0;
            r_rd_fp        <= '0;
            r_wr_fp        <= '0;
            r_count        <= '0;
          end
        end
        S_LOAD: begin
          if (!load_mode) begin
            r_state    <= S_IDLE;
            r_prog_len <= r_wr_ptr;
          end else if (load_valid) begin
            if (r_wr_ptr[ADDR_W])
              r_overflow <= 1'b1;
            else
              r_wr_ptr <= r_wr_ptr + PC_ONE;
          end
        end
        S_RUN: begin
          if (w_pop_halt) begin
            r_state    <= S_HALTED;
            r_halted   <= 1'b1;
            r_inflight <= 1'b0;
            r_rd_fp    <= '0;
            r_wr_fp    <= '0;
            r_count    <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit with a behavioural
// 32x20 instruction memory (one-cycle read latency).
module tb_inst_fetch_unit;

  localparam logic [19:0] HALT = 20'hC0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_mode = 1'b0;
  logic        load_valid = 1'b0;
  logic [19:0] load_inst = '0;
  logic        start = 1'b0;
  logic        freeze = 1'b0;
  logic        mem_wr_en;
  logic [4:0]  mem_wr_addr;
  logic [19:0] mem_wr_data;
  logic        mem_rd_en;
  logic [4:0]  mem_rd_addr;
  logic [19:0] mem_rd_data = '0;
  logic [19:0] inst_out;
  logic        inst_valid;
  logic [5:0]  pc;
  logic [5:0]  prog_len;
  logic        load_overflow;
  logic        halted;

  inst_fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .load_mode    (load_mode),
    .load_valid   (load_valid),
    .load_inst    (load_inst),
    .start        (start),
    .freeze       (freeze),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_data  (mem_rd_data),
    .inst_out     (inst_out),
    .inst_valid   (inst_valid),
    .pc           (pc),
    .prog_len     (prog_len),
    .load_overflow(load_overflow),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int nwr = 0;
  int nrd = 0;
  int npop = 0;
  int nbad = 0;
  int hpop = -100;
  int rd_limit = 32;

  logic [19:0] mem [32];
  logic [19:0] prog [$];
  logic [19:0] sb [$];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  always @(negedge clk) begin
    logic [19:0] exp;
    if (mem_wr_en) begin
      check("wr_addr", 32'(mem_wr_addr), 32'(nwr % 32));
      if (nwr < prog.size())
        check("wr_data", 32'(mem_wr_data), 32'(prog[nwr]));
      nwr++;
    end
    if (mem_rd_en) begin
      nrd++;
      if (int'(mem_rd_addr) >= rd_limit) nbad++;
    end
    if (rst && inst_valid && !freeze) begin
      if (sb.size() == 0)
        check("sb_under", 32'(sb.size()), 1);
      else begin
        exp = sb.pop_front();
        check("inst", 32'(inst_out), 32'(exp));
        npop++;
        if (exp[19:18] == 2'b11) hpop = cyc;
      end
    end
  end

  task automatic chk_zero(input string t);
    check({t, "_wr_en"}, 32'(mem_wr_en), 0);
    check({t, "_wr_addr"}, 32'(mem_wr_addr), 0);
    check({t, "_wr_data"}, 32'(mem_wr_data), 0);
    check({t, "_rd_en"}, 32'(mem_rd_en), 0);
    check({t, "_rd_addr"}, 32'(mem_rd_addr), 0);
    check({t, "_inst"}, 32'(inst_out), 0);
    check({t, "_valid"}, 32'(inst_valid), 0);
    check({t, "_pc"}, 32'(pc), 0);
    check({t, "_len"}, 32'(prog_len), 0);
    check({t, "_ovf"}, 32'(load_overflow), 0);
    check({t, "_halted"}, 32'(halted), 0);
  endtask

  task automatic load_prog();
    nwr = 0;
    load_mode = 1'b1;
    @(posedge clk); #1;
    foreach (prog[i]) begin
      load_valid = 1'b1;
      load_inst  = prog[i];
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
    load_mode  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic push_expected();
    foreach (prog[i]) begin
      sb.push_back(prog[i]);
      if (prog[i][19:18] == 2'b11) return;
    end
    sb.push_back(HALT);
  endtask

  task automatic kick();
    nrd = 0;
    npop = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_halt(input string t);
    int hc;
    hc = -1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (halted) begin
        hc = cyc;
        break;
      end
    end
    check({t, "_halted"}, 32'(halted), 1);
    check({t, "_hlat"}, 32'(hc), 32'(hpop + 1));
    check({t, "_valid"}, 32'(inst_valid), 0);
    check({t, "_sb"}, 32'(sb.size()), 0);
  endtask

  initial begin
    logic [19:0] p8 [$];
    #1;
    chk_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // T1: three instructions ending in HALT
    prog = '{20'h01083, 20'h80ABC, 20'hC0000};
    load_prog();
    check("t1_len", 32'(prog_len), 3);
    push_expected();
    kick();
    check("t1_rd_en", 32'(mem_rd_en), 1);
    check("t1_rd_addr", 32'(mem_rd_addr), 0);
    check("t1_v0", 32'(inst_valid), 0);
    @(posedge clk); #1;
    check("t1_v1", 32'(inst_valid), 0);
    @(posedge clk); #1;
    check("t1_v2", 32'(inst_valid), 1);
    check("t1_head", 32'(inst_out), 32'h01083);
    wait_halt("t1");

    // T2: no HALT in program -> synthetic HALT
    prog = '{20'h12345, 20'h40001};
    load_prog();
    push_expected();
    kick();
    wait_halt("t2");
    check("t2_pc", 32'(pc), 2);

    // T3: freeze holds head, prefetch fills FIFO
    p8 = {};
    for (int i = 0; i < 8; i++)
      p8.push_back({2'b01, 18'(i * 37 + 5)});
    prog = p8;
    load_prog();
    push_expected();
    kick();
    @(posedge clk); #1;
    @(posedge clk); #1;
    freeze = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      check("t3_frz_out", 32'(inst_out), 32'(sb[0]));
      check("t3_frz_v", 32'(inst_valid), 1);
    end
    check("t3_rd_stop", 32'(mem_rd_en), 0);
    check("t3_credit", 32'(nrd - npop), 4);
    freeze = 1'b0;
    wait_halt("t3");
    check("t3_pc", 32'(pc), 8);

    // T4: 33 loads into a 32-deep memory
    prog = {};
    for (int i = 0; i < 33; i++)
      prog.push_back({2'b10, 18'(i * 1021 + 7)});
    load_prog();
    check("t4_nwr", 32'(nwr), 32);
    check("t4_ovf", 32'(load_overflow), 1);
    check("t4_len", 32'(prog_len), 32);

    // T5: HALT at address 1 stops fetch
    prog = '{20'h00111, 20'hC0155, 20'h00222,
             20'h00333, 20'h00444};
    load_prog();
    check("t5_ovf", 32'(load_overflow), 0);
    check("t5_len", 32'(prog_len), 5);
    rd_limit = 2;
    nbad = 0;
    push_expected();
    kick();
    wait_halt("t5");
    check("t5_bad_rd", 32'(nbad), 0);
    check("t5_pc", 32'(pc), 2);
    rd_limit = 32;

    // T6: async reset mid-run, then synthetic HALT
    prog = p8;
    load_prog();
    push_expected();
    kick();
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b0;
    #1 chk_zero("t6_rst");
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    sb.push_back(HALT);
    kick();
    check("t6_v0", 32'(inst_valid), 0);
    @(posedge clk); #1;
    check("t6_v1", 32'(inst_valid), 1);
    check("t6_head", 32'(inst_out), 32'(HALT));
    wait_halt("t6");

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
